// File: rtl/patbuf_arbiter_if.sv
// Host-side burst port of the pattern-buffer arbiter: command, write-beat
// and read-beat handshakes plus the end-of-burst pulse.
interface patbuf_arbiter_if #(
  parameter int unsigned d_width     = 8,
  parameter int unsigned adr_width   = 8,
  parameter int unsigned burst_width = 5
);
  logic                   host_cmd_valid;
  logic                   host_cmd_ready;
  logic                   host_cmd_write;
  logic [adr_width-1:0]   host_adr;
  logic [burst_width-1:0] host_len;
  logic                   host_wvalid;
  logic [d_width-1:0]     host_wdata;
  logic                   host_wready;
  logic                   host_rvalid;
  logic [d_width-1:0]     host_rdata;
  logic                   host_done;

  modport master (
    output host_cmd_valid, host_cmd_write, host_adr, host_len, host_wvalid, host_wdata,
    input  host_cmd_ready, host_wready, host_rvalid, host_rdata, host_done
  );

  modport slave (
    input  host_cmd_valid, host_cmd_write, host_adr, host_len, host_wvalid, host_wdata,
    output host_cmd_ready, host_wready, host_rvalid, host_rdata, host_done
  );
endinterface

// File: rtl/patbuf_arbiter.sv
// Shares the pattern buffer between the PAT core (priority) and host bursts;
// a starvation counter forces a periodic host slot while the core is busy.
module patbuf_arbiter #(
  parameter  int unsigned d_width      = 8,
  parameter  int unsigned bufp_width   = 3,
  parameter  int unsigned fieldp_width = 5,
  parameter  int unsigned burst_width  = 5,
  parameter  int unsigned starve_limit = 4,
  localparam int unsigned A            = bufp_width + fieldp_width
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    core_req,
  input  logic [bufp_width-1:0]   core_bufp,
  input  logic [fieldp_width-1:0] core_fieldp,
  input  logic [fieldp_width-1:0] core_fieldwp,
  input  logic                    core_write_en,
  input  logic [d_width-1:0]      core_wdata,
  output logic [d_width-1:0]      core_rdata,
  output logic                    core_stall,
  patbuf_arbiter_if.slave         host,
  output logic [A-1:0]            pb_adr,
  output logic [A-1:0]            pb_wadr,
  output logic                    pb_write_en,
  output logic [d_width-1:0]      pb_wdata,
  input  logic [d_width-1:0]      pb_rdata
);

  typedef enum logic [1:0] {IDLE, WBURST, RBURST, DONE} state_t;

  state_t                 state, state_n;
  logic [burst_width-1:0] cnt, cnt_n;
  logic [burst_width-1:0] len, len_n;
  logic [A-1:0]           base, base_n;
  logic [3:0]             starve_cnt, starve_n;
  logic                   pending, host_grant;
  logic [A-1:0]           beat_adr;

  assign pending    = ((state == WBURST) && host.host_wvalid) || (state == RBURST);
  assign host_grant = pending && (!core_req || (starve_cnt == 4'(starve_limit)));
  assign core_stall = host_grant && core_req;
  assign beat_adr   = base + A'(cnt);
  assign core_rdata = pb_rdata;

  assign host.host_cmd_ready = (state == IDLE);
  assign host.host_done      = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      len             <= '0;
      base            <= '0;
      starve_cnt      <= '0;
      host.host_rvalid <= 1'b0;
      host.host_rdata  <= '0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      len             <= len_n;
      base            <= base_n;
      starve_cnt      <= starve_n;
      host.host_rvalid <= host_grant && (state == RBURST);
      if (host_grant && (state == RBURST))
        host.host_rdata <= pb_rdata;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    len_n    = len;
    base_n   = base;
    starve_n = (pending && core_req && !host_grant) ? starve_cnt + 4'd1 : '0;
    case (state)
      IDLE: begin
        if (host.host_cmd_valid) begin
          base_n  = host.host_adr;
          len_n   = host.host_len;
          cnt_n   = '0;
          state_n = host.host_cmd_write ? WBURST : RBURST;
        end
      end
      WBURST, RBURST: begin
        if (host_grant) begin
          if (cnt == len) state_n = DONE;
          else            cnt_n   = cnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Core owns both buffer ports unless the host holds the grant this cycle.
  always_comb begin
    pb_adr           = {core_bufp, core_fieldp};
    pb_wadr          = {core_bufp, core_fieldwp};
    pb_write_en      = core_req && core_write_en;
    pb_wdata         = core_wdata;
    host.host_wready = 1'b0;
    if (host_grant) begin
      if (state == WBURST) begin
        pb_wadr          = beat_adr;
        pb_write_en      = 1'b1;
        pb_wdata         = host.host_wdata;
        host.host_wready = 1'b1;
      end else begin
        pb_adr      = beat_adr;
        pb_write_en = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_patbuf_arbiter.sv
// Bench for patbuf_arbiter: directed scenarios plus random core/host traffic,
// checked every cycle against a queue-based model of bursts and buffer contents.
module tb_patbuf_arbiter;
  localparam int unsigned LIMIT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       core_req = 1'b0;
  logic [2:0] core_bufp = '0;
  logic [4:0] core_fieldp = '0;
  logic [4:0] core_fieldwp = '0;
  logic       core_write_en = 1'b0;
  logic [7:0] core_wdata = '0;
  logic [7:0] core_rdata;
  logic       core_stall;
  logic [7:0] pb_adr, pb_wadr, pb_wdata, pb_rdata;
  logic       pb_write_en;

  logic [7:0] pb_mem  [256];
  logic [7:0] ref_mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_a = '0, pre_d = '0;

  patbuf_arbiter_if #(.d_width(8), .adr_width(8), .burst_width(5)) hif ();

  patbuf_arbiter #(
    .d_width(8), .bufp_width(3), .fieldp_width(5), .burst_width(5), .starve_limit(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_bufp(core_bufp), .core_fieldp(core_fieldp),
    .core_fieldwp(core_fieldwp), .core_write_en(core_write_en), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .host(hif.slave),
    .pb_adr(pb_adr), .pb_wadr(pb_wadr), .pb_write_en(pb_write_en),
    .pb_wdata(pb_wdata), .pb_rdata(pb_rdata)
  );

  always #5 clk = ~clk;

  // Pattern buffer model: combinational read, clocked write.
  always @(posedge clk) begin
    if (pre_we)           pb_mem[pre_a]   <= pre_d;
    else if (pb_write_en) pb_mem[pb_wadr] <= pb_wdata;
  end
  assign pb_rdata = pb_mem[pb_adr];

  int unsigned n_pass = 0, n_total = 0, cyc = 0;
  bit          armed = 0;

  // Reference model: outstanding beat addresses of the active burst.
  logic [7:0]  beats[$];
  bit          m_write = 0, m_idle = 1, m_done = 0, m_rv = 0, took = 0;
  logic [7:0]  m_rd = '0;
  int unsigned blocked = 0;

  logic [7:0]  wq[$];
  logic [7:0]  rlog[$];
  int unsigned stall_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    beats.delete();
    m_idle = 1; m_done = 0; m_rv = 0; m_rd = '0; blocked = 0;
  endtask

  task automatic step();
    bit pend, grant, wr;
    logic [7:0] a, ca, cwa;
    @(negedge clk);
    wr    = m_write;
    pend  = (beats.size() > 0) && (!wr || hif.host_wvalid);
    grant = pend && (!core_req || blocked == LIMIT);
    a     = (beats.size() > 0) ? beats[0] : 8'h00;
    ca    = {core_bufp, core_fieldp};
    cwa   = {core_bufp, core_fieldwp};
    if (armed) begin
      chk("cmd_ready", hif.host_cmd_ready, m_idle);
      chk("core_stall", core_stall, grant && core_req);
      chk("wready", hif.host_wready, grant && wr);
      chk("done", hif.host_done, m_done);
      chk("rvalid", hif.host_rvalid, m_rv);
      chk("rdata", hif.host_rdata, m_rd);
      if (grant && wr) begin
        chk("host_we", pb_write_en, 1);
        chk("host_wadr", pb_wadr, a);
        chk("host_wdata", pb_wdata, hif.host_wdata);
      end else if (grant) begin
        chk("host_rd_we", pb_write_en, 0);
        chk("host_radr", pb_adr, a);
      end else begin
        chk("core_we", pb_write_en, core_req && core_write_en);
        if (core_req) chk("core_rdata", core_rdata, ref_mem[ca]);
        if (core_req && core_write_en) begin
          chk("core_wadr", pb_wadr, cwa);
          chk("core_wdata", pb_wdata, core_wdata);
        end
      end
      if (core_stall === 1'b1) stall_log.push_back(cyc);
      if (hif.host_rvalid === 1'b1) rlog.push_back(hif.host_rdata);
    end
    m_rv = grant && !wr;
    if (grant && !wr) m_rd = ref_mem[a];
    if (grant && wr) ref_mem[a] = hif.host_wdata;
    else if (!grant && core_req && core_write_en) ref_mem[cwa] = core_wdata;
    blocked = (pend && core_req && !grant) ? blocked + 1 : 0;
    took = grant;
    if (m_done) begin
      m_done = 0; m_idle = 1;
    end else if (grant) begin
      void'(beats.pop_front());
      if (beats.size() == 0) m_done = 1;
    end else if (m_idle && hif.host_cmd_valid) begin
      m_idle  = 0;
      m_write = hif.host_cmd_write;
      for (int i = 0; i <= int'(hif.host_len); i++) beats.push_back(8'(hif.host_adr + i));
    end
    if (reset) begin
      model_reset();
      armed = 1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_core();
    core_req      = $urandom_range(0, 1);
    core_bufp     = 3'($urandom);
    core_fieldp   = 5'($urandom);
    core_fieldwp  = 5'($urandom);
    core_write_en = $urandom_range(0, 1);
    core_wdata    = 8'($urandom);
  endtask

  // Runs one whole burst: command cycle, beats, and the DONE cycle.
  task automatic burst(input bit wr, input logic [7:0] adr, input logic [4:0] len,
                       input bit rnd_core, input int unsigned wv_pct, output int unsigned cmd_cyc);
    int unsigned guard = 0, di = 0;
    hif.host_cmd_valid = 1; hif.host_cmd_write = wr;
    hif.host_adr = adr; hif.host_len = len;
    hif.host_wvalid = rnd_core ? 1'($urandom) : 1'b0;
    if (rnd_core) rand_core();
    cmd_cyc = cyc;
    step();
    hif.host_cmd_valid = 0;
    while (!m_idle && guard < 500) begin
      if (rnd_core) rand_core();
      hif.host_wvalid = wr ? ($urandom_range(0, 99) < wv_pct) : 1'($urandom);
      hif.host_wdata  = (di < wq.size()) ? wq[di] : 8'($urandom);
      step();
      if (took && wr) di++;
      guard++;
    end
    if (guard >= 500) chk("burst_timeout", guard, 0);
  endtask

  initial begin
    int unsigned c0;
    logic [7:0] v, old[8];
    hif.host_cmd_valid = 0; hif.host_cmd_write = 0; hif.host_adr = '0;
    hif.host_len = '0; hif.host_wvalid = 0; hif.host_wdata = '0;

    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      pre_we = 1; pre_a = 8'(i); pre_d = v; ref_mem[i] = v;
      @(posedge clk); #1;
    end
    pre_we = 0;

    step(); step();
    reset = 0;
    step();
    chk("idle_cmd_ready", hif.host_cmd_ready, 1);
    chk("idle_rvalid", hif.host_rvalid, 0);
    chk("idle_done", hif.host_done, 0);
    chk("idle_stall", core_stall, 0);
    chk("idle_we", pb_write_en, 0);

    wq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    burst(1, 8'h10, 5'd3, 0, 100, c0);
    for (int i = 0; i < 4; i++) chk("wr_10", pb_mem[8'h10 + i], wq[i]);

    rlog.delete();
    burst(0, 8'h10, 5'd3, 0, 0, c0);
    chk("rd_10_n", rlog.size(), 4);
    for (int i = 0; i < 4 && i < rlog.size(); i++) chk("rd_10", rlog[i], wq[i]);

    core_req = 1; core_bufp = 3'd2; core_fieldp = 5'd0; core_fieldwp = 5'd5;
    core_write_en = 1; core_wdata = 8'h5A;
    wq.delete(); stall_log.delete();
    burst(1, 8'h80, 5'd1, 0, 100, c0);
    chk("starve_n", stall_log.size(), 2);
    if (stall_log.size() == 2) begin
      chk("starve_slot0", stall_log[0] - c0, 5);
      chk("starve_slot1", stall_log[1] - c0, 10);
    end
    core_req = 0; core_write_en = 0;

    wq = '{8'h01, 8'h02, 8'h03, 8'h04};
    burst(1, 8'hFE, 5'd3, 0, 100, c0);
    chk("wrap_fe", pb_mem[8'hFE], 8'h01);
    chk("wrap_ff", pb_mem[8'hFF], 8'h02);
    chk("wrap_00", pb_mem[8'h00], 8'h03);
    chk("wrap_01", pb_mem[8'h01], 8'h04);
    rlog.delete();
    burst(0, 8'hFE, 5'd3, 0, 0, c0);
    chk("wrap_rd_n", rlog.size(), 4);
    for (int i = 0; i < 4 && i < rlog.size(); i++) chk("wrap_rd", rlog[i], wq[i]);

    for (int i = 0; i < 8; i++) old[i] = pb_mem[8'h40 + i];
    hif.host_cmd_valid = 1; hif.host_cmd_write = 1; hif.host_adr = 8'h40; hif.host_len = 5'd7;
    step();
    hif.host_cmd_valid = 0;
    hif.host_wvalid = 1; hif.host_wdata = 8'h11; step();
    hif.host_wdata = 8'h22; step();
    hif.host_wvalid = 0; reset = 1; step();
    reset = 0; step();
    chk("rst_cmd_ready", hif.host_cmd_ready, 1);
    chk("rst_beat0", pb_mem[8'h40], 8'h11);
    chk("rst_beat1", pb_mem[8'h41], 8'h22);
    for (int i = 2; i < 8; i++) chk("rst_untouched", pb_mem[8'h40 + i], old[i]);

    wq.delete();
    for (int n = 0; n < 16; n++)
      burst(1'($urandom), 8'($urandom), 5'($urandom), 1, 70, c0);
    core_req = 0; core_write_en = 0;
    step();

    for (int i = 0; i < 256; i++) chk("final_mem", pb_mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end
endmodule
